// File: rtl/peak_dpu_mdu_ctl.sv
// MDU issue/completion control: fixed-latency multiply pipe plus iterative divide FSM
// sharing one writeback port. Optional macro PEAK_MDU_DIV_ZERO_EARLY_EN enables zero-divisor early-out.
module peak_dpu_mdu_ctl #(
   parameter int MUL_LAT = 3,
   parameter int DIV_CYC = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iss_vld,
   input  logic       iss_is_mul,
   input  logic       iss_is_div,
   input  logic [4:0] iss_wr_addr,
   input  logic       iss_div_zero,
   input  logic       flush,
   output logic       mul_busy,
   output logic       mul_wr_vld_ex,
   output logic [4:0] mul_wr_addr_ex,
   output logic       div_busy,
   output logic       div_wr_vld_ex,
   output logic [4:0] div_wr_addr_ex,
   output logic       mul_start,
   output logic       div_start,
   output logic       mdu_err
);

   localparam logic [1:0] D_IDLE = 2'd0;
   localparam logic [1:0] D_RUN  = 2'd1;
   localparam logic [1:0] D_HOLD = 2'd2;
   localparam logic [1:0] D_DONE = 2'd3;

   // vld_pipe[k] is set k cycles after a multiply was accepted
   logic [MUL_LAT:1] vld_pipe;
   logic [1:0]       div_st;
   logic [5:0]       div_cnt;
   logic [5:0]       div_load;
   logic             iss_both, mul_acc, div_acc, mul_wr_nxt;
   logic             mul_viol, div_viol;

   assign iss_both = iss_vld & iss_is_mul & iss_is_div;
   assign mul_acc  = iss_vld & iss_is_mul & ~iss_is_div & ~mul_busy;
   assign div_acc  = iss_vld & iss_is_div & ~iss_is_mul & ~div_busy;
   assign mul_viol = iss_vld & iss_is_mul & ~iss_is_div & mul_busy;
   assign div_viol = iss_vld & iss_is_div & ~iss_is_mul & div_busy;

   assign mul_start     = vld_pipe[1];
   assign mul_busy      = |vld_pipe[MUL_LAT-1:1];
   assign mul_wr_vld_ex = vld_pipe[MUL_LAT];
   // multiply lands on the shared writeback port next cycle
   assign mul_wr_nxt    = vld_pipe[MUL_LAT-1];

   assign div_busy      = (div_st == D_RUN) | (div_st == D_HOLD);
   assign div_wr_vld_ex = (div_st == D_DONE);

`ifdef PEAK_MDU_DIV_ZERO_EARLY_EN
   assign div_load = iss_div_zero ? 6'd0 : 6'(DIV_CYC - 1);
`else
   logic unused_div_zero;
   assign unused_div_zero = iss_div_zero;
   assign div_load        = 6'(DIV_CYC - 1);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe       <= '0;
         div_st         <= D_IDLE;
         div_cnt        <= '0;
         div_start      <= 1'b0;
         mul_wr_addr_ex <= '0;
         div_wr_addr_ex <= '0;
         mdu_err        <= 1'b0;
      end else if (flush) begin
         vld_pipe  <= '0;
         div_st    <= D_IDLE;
         div_cnt   <= '0;
         div_start <= 1'b0;
      end else begin
         vld_pipe  <= {vld_pipe[MUL_LAT-1:1], mul_acc};
         div_start <= div_acc;
         if (mul_acc) mul_wr_addr_ex <= iss_wr_addr;
         if (div_acc) div_wr_addr_ex <= iss_wr_addr;
         if (iss_both | mul_viol | div_viol) mdu_err <= 1'b1;
         case (div_st)
            D_RUN: begin
               if (div_cnt == 6'd0) div_st <= mul_wr_nxt ? D_HOLD : D_DONE;
               else                 div_cnt <= div_cnt - 6'd1;
            end
            D_HOLD: div_st <= D_DONE;
            default: begin
               if (div_acc) begin
                  div_st  <= D_RUN;
                  div_cnt <= div_load;
               end else begin
                  div_st  <= D_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_peak_dpu_mdu_ctl.sv
// Directed bench for peak_dpu_mdu_ctl: u_a uses defaults (MUL_LAT=3, DIV_CYC=32),
// u_b uses DIV_CYC=4 for the writeback collision case; both share stimulus.
module tb_peak_dpu_mdu_ctl;

   logic       clk = 1'b0;
   logic       rst, iss_vld, iss_is_mul, iss_is_div, iss_div_zero, flush;
   logic [4:0] iss_wr_addr;

   logic       a_mul_busy, a_mul_wr_vld, a_div_busy, a_div_wr_vld, a_mul_start, a_div_start, a_err;
   logic [4:0] a_mul_addr, a_div_addr;
   logic       b_mul_busy, b_mul_wr_vld, b_div_busy, b_div_wr_vld, b_mul_start, b_div_start, b_err;
   logic [4:0] b_mul_addr, b_div_addr;

   int vectors = 0;
   int miscompares = 0;
   logic seen;

   always #5 clk = ~clk;

   peak_dpu_mdu_ctl u_a (
      .clk(clk), .rst(rst), .iss_vld(iss_vld), .iss_is_mul(iss_is_mul), .iss_is_div(iss_is_div),
      .iss_wr_addr(iss_wr_addr), .iss_div_zero(iss_div_zero), .flush(flush),
      .mul_busy(a_mul_busy), .mul_wr_vld_ex(a_mul_wr_vld), .mul_wr_addr_ex(a_mul_addr),
      .div_busy(a_div_busy), .div_wr_vld_ex(a_div_wr_vld), .div_wr_addr_ex(a_div_addr),
      .mul_start(a_mul_start), .div_start(a_div_start), .mdu_err(a_err));

   peak_dpu_mdu_ctl #(.MUL_LAT(3), .DIV_CYC(4)) u_b (
      .clk(clk), .rst(rst), .iss_vld(iss_vld), .iss_is_mul(iss_is_mul), .iss_is_div(iss_is_div),
      .iss_wr_addr(iss_wr_addr), .iss_div_zero(iss_div_zero), .flush(flush),
      .mul_busy(b_mul_busy), .mul_wr_vld_ex(b_mul_wr_vld), .mul_wr_addr_ex(b_mul_addr),
      .div_busy(b_div_busy), .div_wr_vld_ex(b_div_wr_vld), .div_wr_addr_ex(b_div_addr),
      .mul_start(b_mul_start), .div_start(b_div_start), .mdu_err(b_err));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one cycle; outputs are sampled 1ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic m, input logic d, input logic [4:0] a, input logic z);
      iss_vld = 1'b1; iss_is_mul = m; iss_is_div = d; iss_wr_addr = a; iss_div_zero = z;
      tick();
      iss_vld = 1'b0; iss_is_mul = 1'b0; iss_is_div = 1'b0; iss_wr_addr = '0; iss_div_zero = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; iss_vld = 1'b0; iss_is_mul = 1'b0; iss_is_div = 1'b0;
      iss_wr_addr = '0; iss_div_zero = 1'b0;
      #1;
      do_reset();

      // reset state
      chk("rst_mul_busy", a_mul_busy, 0);
      chk("rst_mul_wr", a_mul_wr_vld, 0);
      chk("rst_div_busy", a_div_busy, 0);
      chk("rst_div_wr", a_div_wr_vld, 0);
      chk("rst_addrs", {a_mul_addr, a_div_addr}, 0);
      chk("rst_starts_err", {a_mul_start, a_div_start, a_err}, 0);

      // multiply addr 5 at T
      issue(1, 0, 5'd5, 0);                             // now T+1
      chk("mul_t1_start", a_mul_start, 1);
      chk("mul_t1_busy", a_mul_busy, 1);
      chk("mul_t1_wr", a_mul_wr_vld, 0);
      tick();                                           // T+2
      chk("mul_t2_busy", a_mul_busy, 1);
      chk("mul_t2_start", a_mul_start, 0);
      tick();                                           // T+3
      chk("mul_t3_wr", a_mul_wr_vld, 1);
      chk("mul_t3_busy", a_mul_busy, 0);
      chk("mul_t3_addr", a_mul_addr, 5);
      // back-to-back issue in the completion cycle
      issue(1, 0, 5'd7, 0);                             // T+4
      chk("b2b_busy", a_mul_busy, 1);
      chk("b2b_wr", a_mul_wr_vld, 0);
      chk("b2b_start", a_mul_start, 1);
      chk("b2b_addr", a_mul_addr, 7);
      chk("b2b_err", a_err, 0);
      tick(); tick();                                   // T+6
      chk("b2b_done_wr", a_mul_wr_vld, 1);
      tick();

      // divide addr 9 at T, DIV_CYC=32 on u_a, 4 on u_b
      issue(0, 1, 5'd9, 0);                             // T+1
      chk("div_t1_busy", a_div_busy, 1);
      chk("div_t1_start", a_div_start, 1);
      seen = 1'b0;
      for (int i = 2; i <= 32; i++) begin
         tick();
         if (!a_div_busy || a_div_wr_vld) seen = 1'b1;
         if (i == 5) chk("divb_t5_wr", b_div_wr_vld, 1);
      end
      chk("div_busy_span", seen, 0);                    // T+32
      tick();                                           // T+33
      chk("div_t33_wr", a_div_wr_vld, 1);
      chk("div_t33_busy", a_div_busy, 0);
      chk("div_t33_addr", a_div_addr, 9);
      tick();
      chk("div_t34_idle", a_div_wr_vld, 0);

      // writeback collision on u_b: divide at T, multiply at T+2
      do_reset();
      issue(0, 1, 5'd3, 0);                             // T+1
      tick();                                           // T+2
      issue(1, 0, 5'd4, 0);                             // T+3
      tick(); tick();                                   // T+5
      chk("col_t5_mul_wr", b_mul_wr_vld, 1);
      chk("col_t5_div_busy", b_div_busy, 1);
      chk("col_t5_div_wr", b_div_wr_vld, 0);
      tick();                                           // T+6
      chk("col_t6_div_wr", b_div_wr_vld, 1);
      chk("col_t6_div_busy", b_div_busy, 0);
      chk("col_t6_mul_wr", b_mul_wr_vld, 0);
      chk("col_t6_addr", b_div_addr, 3);

      // flush a running divide at T+10
      do_reset();
      issue(0, 1, 5'd10, 0);                            // T+1
      for (int i = 2; i <= 10; i++) tick();             // T+10
      chk("fl_t10_busy", a_div_busy, 1);
      flush = 1'b1;
      tick();                                           // T+11
      flush = 1'b0;
      chk("fl_t11_busy", a_div_busy, 0);
      chk("fl_t11_addr", a_div_addr, 10);
      seen = a_div_wr_vld;
      for (int i = 0; i < 30; i++) begin
         tick();
         seen = seen | a_div_wr_vld | a_div_busy;
      end
      chk("fl_no_wr", seen, 0);

      // reset mid-multiply discards it
      issue(1, 0, 5'd2, 0);
      do_reset();
      chk("rstmid_mul_wr", {a_mul_wr_vld, a_mul_busy, a_mul_addr}, 0);

      // illegal mul+div issue is sticky and ignored
      chk("err_pre", a_err, 0);
      issue(1, 1, 5'd6, 0);
      chk("err_set", a_err, 1);
      chk("err_ignored", {a_mul_busy, a_div_busy, a_mul_start, a_div_start}, 0);
      tick(); tick();
      chk("err_sticky", a_err, 1);
      do_reset();
      chk("err_cleared", a_err, 0);

      // multiply issued while busy flags an error
      issue(1, 0, 5'd1, 0);
      issue(1, 0, 5'd8, 0);
      chk("busy_issue_err", a_err, 1);
      chk("busy_issue_addr", a_mul_addr, 1);
      do_reset();

      // zero-divisor divide
      issue(0, 1, 5'd12, 1);                            // T+1
      chk("dz_t1_busy", a_div_busy, 1);
      tick();                                           // T+2
`ifdef PEAK_MDU_DIV_ZERO_EARLY_EN
      chk("dz_t2_wr", a_div_wr_vld, 1);
      chk("dz_t2_busy", a_div_busy, 0);
`else
      chk("dz_t2_wr", a_div_wr_vld, 0);
      chk("dz_t2_busy", a_div_busy, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/peak_dpu_mdu_ctl.md
PEAK_DPU_MDU_CTL -- requirements
Module: peak_dpu_mdu_ctl

Interface
REQ-001 Parameter MUL_LAT, default 3, is the cycles from multiply issue to result; legal range 2..15.
REQ-002 Parameter DIV_CYC, default 32, is the number of divide busy cycles; legal range 1..63.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port iss_vld, input, 1 bit: an instruction is issued to the MDU this cycle.
REQ-006 Port iss_is_mul, input, 1 bit: the issued instruction is a multiply.
REQ-007 Port iss_is_div, input, 1 bit: the issued instruction is a divide or remainder.
REQ-008 Port iss_wr_addr, input, 5 bits: destination register of the issued instruction.
REQ-009 Port iss_div_zero, input, 1 bit: the issued divide has a zero divisor.
REQ-010 Port flush, input, 1 bit: kills all in-flight MDU operations.
REQ-011 Port mul_busy, output, 1 bit: the multiply is executing and its result is not yet available.
REQ-012 Port mul_wr_vld_ex, output, 1 bit: the multiply result is on the writeback and forward path this cycle.
REQ-013 Port mul_wr_addr_ex, output, 5 bits: destination register of the current or last multiply.
REQ-014 Port div_busy, output, 1 bit: the divide is executing.
REQ-015 Port div_wr_vld_ex, output, 1 bit: the divide result is valid this cycle.
REQ-016 Port div_wr_addr_ex, output, 5 bits: destination register of the current or last divide.
REQ-017 Port mul_start, output, 1 bit: registered pulse that launches the multiplier datapath.
REQ-018 Port div_start, output, 1 bit: registered pulse that launches the divider datapath.
REQ-019 Port mdu_err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-020 A multiply is accepted in cycle T when iss_vld & iss_is_mul & ~iss_is_div & ~mul_busy; mul_wr_addr_ex latches iss_wr_addr at the end of T.
REQ-021 For an accepted multiply, mul_start=1 in T+1, mul_busy=1 in T+1..T+MUL_LAT-1, and mul_wr_vld_ex=1 with mul_busy=0 in T+MUL_LAT only.
REQ-022 A divide is accepted under the same rule as REQ-020 with iss_is_div, ~iss_is_mul and ~div_busy; div_wr_addr_ex latches iss_wr_addr.
REQ-023 The divide FSM has states D_IDLE, D_RUN, D_HOLD and D_DONE, with a 6-bit down-counter loaded with DIV_CYC-1 on acceptance.
REQ-024 Divide transitions: D_IDLE->D_RUN on accept; D_RUN counts down; at count 0, D_RUN->D_DONE, or D_RUN->D_HOLD if the multiply would assert mul_wr_vld_ex in the same next cycle; D_HOLD->D_DONE; D_DONE->D_IDLE, or D_DONE->D_RUN on a new accept.
REQ-025 div_busy=1 in D_RUN and D_HOLD; div_wr_vld_ex=1 with div_busy=0 only in D_DONE; div_start=1 in the first D_RUN cycle.
REQ-026 mul_wr_vld_ex and div_wr_vld_ex are never both 1 in the same cycle, because they share the alu0 writeback port and the multiply wins.
REQ-027 An issue in the completion cycle of the same unit (busy=0, wr_vld=1) is accepted, and the unit is busy again in the next cycle.
REQ-028 The multiply and divide units run concurrently and independently, except for the arbitration in REQ-024.
REQ-029 mul_wr_addr_ex and div_wr_addr_ex hold their value from acceptance through completion and afterwards until the next accept.
REQ-030 Any of the following sets mdu_err, and the issue is ignored:
- iss_vld & iss_is_mul & iss_is_div;
- a multiply issued while mul_busy=1;
- a divide issued while div_busy=1.
REQ-031 flush has priority over everything: in the next cycle both units are idle, all busy, wr_vld and start outputs are 0, the address outputs hold, and an issue in the flush cycle is dropped.

Reset
REQ-032 On rst=1 at a clock edge, all outputs become 0 in the next cycle, including the address outputs and mdu_err; the divide FSM enters D_IDLE and the counters clear.
REQ-033 Reset mid-operation discards the operation with no wr_vld pulse; rst has priority over flush and issue.

Configuration
REQ-034 Macro PEAK_MDU_DIV_ZERO_EARLY_EN is the single configuration option.
REQ-035 With PEAK_MDU_DIV_ZERO_EARLY_EN defined, a divide accepted with iss_div_zero=1 loads count 0, giving one busy cycle and div_wr_vld_ex in T+2, subject to REQ-024.
REQ-036 Without PEAK_MDU_DIV_ZERO_EARLY_EN, iss_div_zero is ignored and every divide takes DIV_CYC busy cycles.

Verification
REQ-037 Multiply, MUL_LAT=3: multiply issued at T with addr 5 -> mul_start at T+1; mul_busy at T+1 and T+2; mul_wr_vld_ex=1, mul_busy=0, addr 5 at T+3.
REQ-038 Divide, DIV_CYC=32: divide issued at T with addr 9 -> div_busy at T+1..T+32; div_wr_vld_ex with addr 9 at T+33.
REQ-039 Collision, DIV_CYC=4, MUL_LAT=3: divide at T and multiply at T+2 -> mul_wr_vld_ex at T+5; div_busy held through T+5; div_wr_vld_ex at T+6.
REQ-040 Back-to-back: multiply issued in its own completion cycle -> mul_busy=1 in the next cycle, and mdu_err stays 0.
REQ-041 Flush at T+10 of a running divide -> div_busy=0 at T+11, and no div_wr_vld_ex ever follows.
REQ-042 Error and early-out:
- iss_is_mul and iss_is_div both set -> mdu_err=1 and sticky until rst;
- with the macro defined, a zero-divisor divide at T -> div_wr_vld_ex at T+2.
